matrix_scan_controller: RTL and testbench

Time-multiplexed scan controller for the CPLD kit's 5×7 LED matrix. It drives one column at a time and presents that column's row pattern. It takes symmetric two-column images from the water-level decoder and from an alarm image decoder, and chooses which image is shown. It also rotates between the two images while an alarm is active, and blinks the water image at critical level. It sits between the image decoders and the matrix pins.

---
 rtl/matrix_scan_controller_if.sv | 24 ++
 rtl/matrix_scan_controller.sv | 95 +++++++++
 tb/tb_matrix_scan_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/matrix_scan_controller_if.sv
// matrix_scan_controller_if: image inputs and matrix pin outputs of the 5x7 LED scan controller
// Ports: master drives enable, images, alarm_active, water_critical and receives col_n, row_n, image_sel, frame_tick;
//        slave is the controller side with the opposite directions.
interface matrix_scan_controller_if;
  logic       enable;
  logic [6:0] water_col_1;
  logic [6:0] water_col_0;
  logic [6:0] alarm_col_1;
  logic [6:0] alarm_col_0;
  logic       alarm_active;
  logic       water_critical;
  logic [4:0] col_n;
  logic [6:0] row_n;
  logic       image_sel;
  logic       frame_tick;
  modport master (
    output enable, water_col_1, water_col_0, alarm_col_1, alarm_col_0, alarm_active, water_critical,
    input  col_n, row_n, image_sel, frame_tick
  );
  modport slave (
    input  enable, water_col_1, water_col_0, alarm_col_1, alarm_col_0, alarm_active, water_critical,
    output col_n, row_n, image_sel, frame_tick
  );
endinterface

// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: time-multiplexed 5x7 LED scan with water/alarm image rotation and critical blink
// Ports: clk, rst_n (async active-low); bus (slave) carries enable, the two-column images,
//        alarm_active, water_critical in and col_n, row_n, image_sel, frame_tick out (all registered).
module matrix_scan_controller #(
  parameter int SCAN_DIV     = 1000,
  parameter int DWELL_FRAMES = 250,
  parameter int BLINK_FRAMES = 50
) (
  input logic clk,
  input logic rst_n,
  matrix_scan_controller_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  typedef enum logic {S_WATER, S_ALARM} state_t;
  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [2:0]    r_col, w_col_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase_off;
  logic [6:0]    r_row, w_row, w_img;
  logic [4:0]    r_col_n;
  logic [6:0]    r_row_n;
  logic          r_frame_tick;
  logic          w_slot_end, w_wrap, w_dwell_end, w_blink_end, w_blank, w_outer;
  assign w_slot_end  = r_presc == PW'(SCAN_DIV - 1);
  assign w_wrap      = w_slot_end && r_col == 3'd4;
  assign w_presc_nxt = w_slot_end ? '0 : r_presc + PW'(1);
  assign w_col_nxt   = !w_slot_end ? r_col : (w_wrap ? 3'd0 : r_col + 3'd1);
  assign w_dwell_end = r_dwell == DW'(DWELL_FRAMES - 1);
  assign w_blink_end = r_blink_cnt == BW'(BLINK_FRAMES - 1);
  assign w_outer     = r_col == 3'd0 || r_col == 3'd4;
  assign w_img       = r_state == S_ALARM ? (w_outer ? bus.alarm_col_1 : bus.alarm_col_0)
                                          : (w_outer ? bus.water_col_1 : bus.water_col_0);
  assign w_blank     = bus.water_critical && r_state == S_WATER && r_phase_off;
  // Rows are captured during the blank cycle of each slot and held for the rest of it.
  assign w_row       = r_presc == '0 ? (w_blank ? 7'h00 : w_img) : r_row;
  assign bus.col_n      = r_col_n;
  assign bus.row_n      = r_row_n;
  assign bus.image_sel  = r_state == S_ALARM;
  assign bus.frame_tick = r_frame_tick;
  // Scheduler only moves at a frame boundary; with no alarm in WATER the dwell stays at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    if (w_wrap && r_state == S_WATER) begin
      w_state_nxt = bus.alarm_active && w_dwell_end ? S_ALARM : S_WATER;
      w_dwell_nxt = bus.alarm_active && !w_dwell_end ? r_dwell + DW'(1) : '0;
    end else if (w_wrap) begin
      w_state_nxt = !bus.alarm_active || w_dwell_end ? S_WATER : S_ALARM;
      w_dwell_nxt = !bus.alarm_active || w_dwell_end ? '0 : r_dwell + DW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WATER;
      r_dwell <= '0;
    end else begin
      r_state <= bus.enable ? w_state_nxt : S_WATER;
      r_dwell <= bus.enable ? w_dwell_nxt : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_blink_cnt  <= '0;
      r_phase_off  <= 1'b0;
      r_col_n      <= 5'h1F;
      r_row_n      <= 7'h7F;
      r_frame_tick <= 1'b0;
    end else if (!bus.enable) begin
      r_presc      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_blink_cnt  <= '0;
      r_phase_off  <= 1'b0;
      r_col_n      <= 5'h1F;
      r_row_n      <= 7'h7F;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row;
      r_frame_tick <= w_wrap;
      r_blink_cnt  <= !bus.water_critical ? '0 : !w_wrap ? r_blink_cnt : w_blink_end ? '0 : r_blink_cnt + BW'(1);
      r_phase_off  <= bus.water_critical && (r_phase_off ^ (w_wrap && w_blink_end));
      r_col_n      <= w_presc_nxt == '0 ? 5'h1F : ~(5'd1 << w_col_nxt);
      r_row_n      <= w_presc_nxt == '0 ? 7'h7F : ~w_row;
    end
  end
endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller: directed and randomized check of the scan controller against a frame-level model
module tb_matrix_scan_controller;
  localparam int S = 4, D = 3, B = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0;
  matrix_scan_controller_if bus();
  matrix_scan_controller #(.SCAN_DIV(S), .DWELL_FRAMES(D), .BLINK_FRAMES(B)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: t is the cycle index since scan start; slot = t/S, column = slot%5, frame ends every 5*S cycles.
  int t = 0, m_dwell = 0, m_bcnt = 0, c = 0;
  bit m_alarm = 0, m_off = 0, m_tick = 0;
  logic [6:0] m_rows = 7'h00;
  logic [4:0] e_col_n = 5'h1F;
  logic [6:0] e_row_n = 7'h7F;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !bus.enable) begin
      t = 0; m_dwell = 0; m_bcnt = 0; m_alarm = 0; m_off = 0; m_tick = 0;
      m_rows = 7'h00; e_col_n = 5'h1F; e_row_n = 7'h7F;
    end else begin
      c = (t / S) % 5;
      if (t % S == 0)
        m_rows = (bus.water_critical && !m_alarm && m_off) ? 7'h00 :
                 (c == 0 || c == 4) ? (m_alarm ? bus.alarm_col_1 : bus.water_col_1)
                                    : (m_alarm ? bus.alarm_col_0 : bus.water_col_0);
      m_tick = (t % (5 * S)) == 5 * S - 1;
      if (m_tick) begin
        if (m_alarm) begin
          if (!bus.alarm_active || m_dwell == D - 1) begin m_alarm = 0; m_dwell = 0; end
          else m_dwell++;
        end else if (bus.alarm_active) begin
          if (m_dwell == D - 1) begin m_alarm = 1; m_dwell = 0; end
          else m_dwell++;
        end else m_dwell = 0;
        if (bus.water_critical) begin
          m_bcnt++;
          if (m_bcnt == B) begin m_bcnt = 0; m_off = !m_off; end
        end
      end
      if (!bus.water_critical) begin m_bcnt = 0; m_off = 0; end
      t++;
      e_col_n = (t % S == 0) ? 5'h1F : ~(5'd1 << ((t / S) % 5));
      e_row_n = (t % S == 0) ? 7'h7F : ~m_rows;
    end
  end
  always @(negedge clk) begin
    chk("col_n", bus.col_n, e_col_n);
    chk("row_n", bus.row_n, e_row_n);
    chk("image_sel", bus.image_sel, m_alarm);
    chk("frame_tick", bus.frame_tick, m_tick);
  end
  initial begin
    bus.enable = 1; bus.alarm_active = 0; bus.water_critical = 0;
    bus.water_col_1 = 7'h7F; bus.water_col_0 = 7'h03;
    bus.alarm_col_1 = 7'h55; bus.alarm_col_0 = 7'h2A;
    repeat (2) @(negedge clk);
    chk("rst_col_n", bus.col_n, 5'h1F);
    chk("rst_row_n", bus.row_n, 7'h7F);
    chk("rst_sel", bus.image_sel, 0);
    chk("rst_tick", bus.frame_tick, 0);
    rst_n = 1;
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      if (k == 1) begin chk("c0_col", bus.col_n, 5'h1E); chk("c0_row", bus.row_n, 7'h00); end
      if (k == 4) chk("c1_blank", bus.col_n, 5'h1F);
      if (k == 5) begin chk("c1_col", bus.col_n, 5'h1D); chk("c1_row", bus.row_n, 7'h7C); bus.alarm_active = 1; end
      if (k == 19) chk("tick_pre", bus.frame_tick, 0);
      if (k == 20) chk("tick", bus.frame_tick, 1);
      if (k == 59) chk("sel_pre", bus.image_sel, 0);
      if (k == 60) chk("sel_on", bus.image_sel, 1);
      if (k == 61) chk("alarm_row", bus.row_n, 7'h2A);
      if (k == 119) chk("sel_hold", bus.image_sel, 1);
      if (k == 120) chk("sel_back", bus.image_sel, 0);
      if (k == 180) chk("sel_again", bus.image_sel, 1);
      if (k == 190) bus.alarm_active = 0;
      if (k == 199) chk("drop_pre", bus.image_sel, 1);
      if (k == 200) chk("drop", bus.image_sel, 0);
    end
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.alarm_active = ~bus.alarm_active;
      if ($urandom_range(0, 59) == 0) bus.water_critical = ~bus.water_critical;
      if ($urandom_range(0, 3) == 0)
        case ($urandom_range(0, 3))
          0: bus.water_col_1 = 7'($urandom);
          1: bus.water_col_0 = 7'($urandom);
          2: bus.alarm_col_1 = 7'($urandom);
          default: bus.alarm_col_0 = 7'($urandom);
        endcase
      bus.enable = bus.enable ? ($urandom_range(0, 599) != 0) : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 0;
        #1;
        chk("arst_col_n", bus.col_n, 5'h1F);
        chk("arst_row_n", bus.row_n, 7'h7F);
        chk("arst_sel", bus.image_sel, 0);
        @(negedge clk);
        rst_n = 1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
